// File: rtl/ebi_cbus_bridge.sv
// Bridge from the host CPU's asynchronous external bus to single-cycle cbus strobes.
// It holds the address across the fixed register-block read latency and stalls the host with ebi_wait.

module ebi_cbus_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sr;

    // Reset to the inactive level so leaving reset never looks like a strobe edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '1;
        else        sr <= {sr[STAGES-2:0], d};
    end

    assign q = sr[STAGES-1];
endmodule

module ebi_cbus_bridge #(
    parameter int CBUS_ADDR_WIDTH = 12,
    parameter int CBUS_DATA_WIDTH = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int RD_LATENCY      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ebi_cs_n,
    input  logic                       ebi_oe_n,
    input  logic                       ebi_we_n,
    input  logic [CBUS_ADDR_WIDTH-1:0] ebi_addr,
    input  logic [CBUS_DATA_WIDTH-1:0] ebi_data_in,
    output logic [CBUS_DATA_WIDTH-1:0] ebi_data_out,
    output logic                       ebi_data_oe,
    output logic                       ebi_wait,
    output logic [CBUS_ADDR_WIDTH-1:0] cbus_addr,
    output logic [CBUS_DATA_WIDTH-1:0] cbus_wdata,
    output logic                       cbus_we,
    output logic                       cbus_oe,
    input  logic [CBUS_DATA_WIDTH-1:0] cbus_rdata,
    output logic [7:0]                 proto_err_cnt
);
    localparam int CNT_W = $clog2(RD_LATENCY + 2);
    localparam int NUM_STROBES = 3;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, RELEASE} state_t;

    state_t state, state_nxt;

    logic [NUM_STROBES-1:0] strobe_raw, strobe_s;
    logic                   cs_s, oe_s, we_s;
    logic                   oe_prev, we_prev;
    logic                   oe_fall, we_fall;
    logic [CNT_W-1:0]       cnt;

    logic wr_go, rd_go, overlap, rd_last, host_reading;
    logic do_wr, do_rd, drive_on, drive_off, err_inc;

    assign strobe_raw = {ebi_we_n, ebi_oe_n, ebi_cs_n};

    for (genvar i = 0; i < NUM_STROBES; i++) begin : g_sync
        ebi_cbus_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (strobe_raw[i]),
            .q     (strobe_s[i])
        );
    end

    assign cs_s = strobe_s[0];
    assign oe_s = strobe_s[1];
    assign we_s = strobe_s[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oe_prev <= 1'b1;
            we_prev <= 1'b1;
        end else begin
            oe_prev <= oe_s;
            we_prev <= we_s;
        end
    end

    assign oe_fall = oe_prev & ~oe_s;
    assign we_fall = we_prev & ~we_s;

    assign wr_go        = we_fall & ~cs_s & oe_s;
    assign rd_go        = oe_fall & ~cs_s & we_s;
    assign overlap      = ~cs_s & ~we_s & ~oe_s;
    assign rd_last      = (cnt == CNT_W'(1));
    assign host_reading = ~oe_s & ~cs_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (overlap || wr_go) state_nxt = RELEASE;
                else if (rd_go)       state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (rd_last) state_nxt = host_reading ? RD_DRIVE : IDLE;
            end
            RD_DRIVE: begin
                if (oe_s || cs_s) state_nxt = IDLE;
            end
            RELEASE: begin
                if ((we_s && oe_s) || cs_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        do_wr     = 1'b0;
        do_rd     = 1'b0;
        drive_on  = 1'b0;
        drive_off = 1'b0;
        err_inc   = 1'b0;
        case (state)
            IDLE: begin
                do_wr   = wr_go;
                do_rd   = rd_go;
                err_inc = overlap;
            end
            RD_WAIT: begin
                drive_on = rd_last & host_reading;
                // A write strobe mid-read and a read abandoned before data is ready both count.
                err_inc  = we_fall | (rd_last & ~host_reading);
            end
            RD_DRIVE: drive_off = oe_s | cs_s;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cbus_we       <= 1'b0;
            cbus_oe       <= 1'b0;
            cbus_addr     <= '0;
            cbus_wdata    <= '0;
            cnt           <= '0;
            ebi_wait      <= 1'b0;
            ebi_data_out  <= '0;
            ebi_data_oe   <= 1'b0;
            proto_err_cnt <= '0;
        end else begin
            cbus_we <= do_wr;
            cbus_oe <= do_rd;
            if (do_wr || do_rd) cbus_addr <= ebi_addr;
            if (do_wr)          cbus_wdata <= ebi_data_in;

            // One extra count so the capture lands on the cycle data is valid.
            if (do_rd)            cnt <= CNT_W'(RD_LATENCY + 1);
            else if (cnt != '0)   cnt <= cnt - CNT_W'(1);

            if (do_rd)                            ebi_wait <= 1'b1;
            else if (state == RD_WAIT && rd_last) ebi_wait <= 1'b0;

            if (state == RD_WAIT && rd_last) ebi_data_out <= cbus_rdata;

            if (drive_on)       ebi_data_oe <= 1'b1;
            else if (drive_off) ebi_data_oe <= 1'b0;

            if (err_inc && proto_err_cnt != 8'hFF) proto_err_cnt <= proto_err_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_ebi_cbus_bridge.sv
// Bench for ebi_cbus_bridge: host transaction table, cbus scoreboard and a latency-4 register model.

module tb_ebi_cbus_bridge;
    localparam int K_WR = 0, K_RD = 1, K_ABORT = 2, K_OVL = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ebi_cs_n = 1'b1, ebi_oe_n = 1'b1, ebi_we_n = 1'b1;
    logic [11:0] ebi_addr = '0;
    logic [7:0]  ebi_data_in = '0;
    logic [7:0]  ebi_data_out;
    logic        ebi_data_oe, ebi_wait;
    logic [11:0] cbus_addr;
    logic [7:0]  cbus_wdata;
    logic        cbus_we, cbus_oe;
    logic [7:0]  cbus_rdata;
    logic [7:0]  proto_err_cnt;

    typedef struct {
        int          kind;
        logic [11:0] addr;
        logic [7:0]  data;
        logic [7:0]  exp_rd;
        int          hold;
        logic [7:0]  exp_err;
    } vec_t;

    typedef struct {
        logic        is_rd;
        logic [11:0] addr;
        logic [7:0]  data;
    } acc_t;

    vec_t vecs[11];
    acc_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    logic [7:0] regmem [16];
    logic [3:0] sh;

    ebi_cbus_bridge dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ebi_cs_n      (ebi_cs_n),
        .ebi_oe_n      (ebi_oe_n),
        .ebi_we_n      (ebi_we_n),
        .ebi_addr      (ebi_addr),
        .ebi_data_in   (ebi_data_in),
        .ebi_data_out  (ebi_data_out),
        .ebi_data_oe   (ebi_data_oe),
        .ebi_wait      (ebi_wait),
        .cbus_addr     (cbus_addr),
        .cbus_wdata    (cbus_wdata),
        .cbus_we       (cbus_we),
        .cbus_oe       (cbus_oe),
        .cbus_rdata    (cbus_rdata),
        .proto_err_cnt (proto_err_cnt)
    );

    always #5 clk = ~clk;

    // Register block model: data valid exactly RD_LATENCY cycles after cbus_oe, junk otherwise.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh <= '0;
            for (int i = 0; i < 16; i++) regmem[i] <= 8'(i * 16);
        end else begin
            sh <= {sh[2:0], cbus_oe};
            if (cbus_we) regmem[cbus_addr[3:0]] <= cbus_wdata;
        end
    end
    assign cbus_rdata = sh[3] ? regmem[cbus_addr[3:0]] : 8'hEE;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        acc_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (cbus_we || cbus_oe)) begin
                check("we_oe_exclusive", cbus_we & cbus_oe, 0);
                check("sb_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("strobe_kind", cbus_oe, e.is_rd);
                    check("strobe_addr", cbus_addr, e.addr);
                    if (!e.is_rd) check("strobe_wdata", cbus_wdata, e.data);
                end
            end
        end
    endtask

    task automatic wait_cbus_oe();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!cbus_oe && t < 20);
        check("rd_start", cbus_oe, 1);
    endtask

    task automatic host_write(input logic [11:0] a, input logic [7:0] d, input int hold);
        @(posedge clk); #1;
        ebi_cs_n = 0; ebi_addr = a; ebi_data_in = d;
        exp_q.push_back('{1'b0, a, d});
        @(posedge clk); #1 ebi_we_n = 0;
        repeat (6 + hold) @(posedge clk);
        #1 ebi_we_n = 1;
        repeat (4) @(posedge clk);
        #1 ebi_cs_n = 1;
        repeat (4) @(posedge clk);
        check("wr_done", exp_q.size(), 0);
    endtask

    task automatic host_read(input logic [11:0] a, input logic [7:0] exp_d, input bit abort);
        int  n;
        bit  addr_ok, oe_seen;
        @(posedge clk); #1;
        ebi_cs_n = 0; ebi_addr = a;
        exp_q.push_back('{1'b1, a, 8'h00});
        @(posedge clk); #1 ebi_oe_n = 0;
        wait_cbus_oe();
        check("wait_at_oe", ebi_wait, 1);
        if (abort) ebi_oe_n = 1;
        n = 0; addr_ok = 1; oe_seen = 0;
        do begin
            @(negedge clk);
            n++;
            if (cbus_addr !== a) addr_ok = 0;
            if (ebi_data_oe) oe_seen = 1;
        end while (ebi_wait && n < 20);
        check("wait_len", n, 5);
        check("rd_addr_hold", addr_ok, 1);
        if (!abort) begin
            check("rd_data", ebi_data_out, exp_d);
            check("rd_drive", ebi_data_oe, 1);
            repeat (3) @(negedge clk);
            check("rd_drive_held", {ebi_data_oe, ebi_data_out}, {1'b1, exp_d});
            ebi_oe_n = 1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (ebi_data_oe && n < 8);
            check("rd_release", ebi_data_oe, 0);
        end else begin
            repeat (6) begin
                @(negedge clk);
                if (ebi_data_oe) oe_seen = 1;
            end
            check("abort_no_drive", oe_seen, 0);
        end
        #1 ebi_cs_n = 1;
        repeat (4) @(posedge clk);
    endtask

    task automatic host_overlap(input int gap);
        @(posedge clk); #1 ebi_cs_n = 0;
        @(posedge clk); #1 begin ebi_we_n = 0; ebi_oe_n = 0; end
        repeat (5 + gap) @(posedge clk);
        #1 begin ebi_we_n = 1; ebi_oe_n = 1; end
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{K_WR,    12'h002, 8'hA5, 8'h00, 50, 8'd0};
        vecs[1]  = '{K_RD,    12'h001, 8'h00, 8'h10, 0,  8'd0};
        vecs[2]  = '{K_ABORT, 12'h004, 8'h00, 8'h00, 0,  8'd1};
        vecs[3]  = '{K_WR,    12'h00F, 8'h3C, 8'h00, 0,  8'd1};
        vecs[4]  = '{K_RD,    12'h00F, 8'h00, 8'h3C, 0,  8'd1};
        vecs[5]  = '{K_OVL,   12'h000, 8'h00, 8'h00, 0,  8'd2};
        vecs[6]  = '{K_WR,    12'hFFF, 8'hFF, 8'h00, 0,  8'd2};
        vecs[7]  = '{K_RD,    12'hFFF, 8'h00, 8'hFF, 0,  8'd2};
        vecs[8]  = '{K_RD,    12'hABC, 8'h00, 8'hC0, 0,  8'd2};
        vecs[9]  = '{K_WR,    12'h000, 8'h00, 8'h00, 0,  8'd2};
        vecs[10] = '{K_RD,    12'h000, 8'h00, 8'h00, 0,  8'd2};

        fork monitor(); join_none

        // Reset release with the bus idle: everything stays quiet.
        repeat (3) @(posedge clk);
        #3 rst_n = 1;
        repeat (20) begin
            @(negedge clk);
            check("reset_quiet", {ebi_data_out, ebi_data_oe, ebi_wait, cbus_addr, cbus_wdata,
                                  cbus_we, cbus_oe, proto_err_cnt}, 0);
        end

        for (int i = 0; i < 11; i++) begin
            case (vecs[i].kind)
                K_WR:    host_write(vecs[i].addr, vecs[i].data, vecs[i].hold);
                K_RD:    host_read(vecs[i].addr, vecs[i].exp_rd, 1'b0);
                K_ABORT: host_read(vecs[i].addr, 8'h00, 1'b1);
                default: begin
                    host_overlap(0);
                    @(posedge clk); #1 ebi_cs_n = 1;
                    repeat (3) @(posedge clk);
                end
            endcase
            check("err_cnt", proto_err_cnt, vecs[i].exp_err);
            check("no_leftover", exp_q.size(), 0);
        end

        // Saturation: 300 overlapping strobe pairs.
        for (int i = 0; i < 300; i++) host_overlap(0);
        #1 ebi_cs_n = 1;
        repeat (3) @(posedge clk);
        check("err_saturated", proto_err_cnt, 8'd255);

        // Asynchronous reset in the middle of a read.
        @(posedge clk); #1 begin ebi_cs_n = 0; ebi_addr = 12'h005; end
        exp_q.push_back('{1'b1, 12'h005, 8'h00});
        @(posedge clk); #1 ebi_oe_n = 0;
        wait_cbus_oe();
        repeat (2) @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("rst_wait", ebi_wait, 0);
        check("rst_data_oe", ebi_data_oe, 0);
        check("rst_outputs", {ebi_data_out, cbus_addr, cbus_oe, proto_err_cnt}, 0);
        exp_q.delete();
        ebi_oe_n = 1; ebi_cs_n = 1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1;
        repeat (10) begin
            @(negedge clk);
            check("post_rst_wait", {ebi_wait, ebi_data_oe}, 0);
        end
        host_write(12'h003, 8'h01, 0);
        check("post_rst_err", proto_err_cnt, 0);
        check("post_rst_addr", cbus_addr, 12'h003);
        check("post_rst_wdata", cbus_wdata, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ebi_cbus_bridge.md
Name: ebi_cbus_bridge

Overview:
- Upstream neighbour of the cbus register block.
- Converts the host CPU's asynchronous external bus (chip-select, read and write strobes, address, 8-bit data) into single-cycle synchronous cbus strobes.
- Holds cbus_addr stable for the register block's fixed 4-cycle read latency, returns read data to the CPU, and uses a wait signal to stall the CPU until that data is valid.
- Counts host protocol violations.

Parameters:
- CBUS_ADDR_WIDTH, 12, width of the address on the external bus and on cbus.
- CBUS_DATA_WIDTH, 8, data width.
- SYNC_STAGES, 2, flip-flop depth of the strobe synchronisers (minimum 2).
- RD_LATENCY, 4, cycles from the cbus_oe pulse to valid cbus_rdata at the register block output.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ebi_cs_n  in  1  CPU chip select, async, active low
- ebi_oe_n  in  1  CPU read strobe, async, active low
- ebi_we_n  in  1  CPU write strobe, async, active low
- ebi_addr  in  CBUS_ADDR_WIDTH  CPU address
- ebi_data_in  in  CBUS_DATA_WIDTH  CPU write data (from the pad buffer)
- ebi_data_out  out  CBUS_DATA_WIDTH  read data to the pad buffer
- ebi_data_oe  out  1  pad output enable, 1 = drive
- ebi_wait  out  1  CPU stall, 1 = data not yet valid
- cbus_addr  out  CBUS_ADDR_WIDTH  cbus address
- cbus_wdata  out  CBUS_DATA_WIDTH  cbus write data
- cbus_we  out  1  one-cycle write pulse
- cbus_oe  out  1  one-cycle read pulse
- cbus_rdata  in  CBUS_DATA_WIDTH  read data from the register block
- proto_err_cnt  out  8  saturating protocol-error count

Behaviour:
Reset (rst_n = 0, async, also mid-operation):
- State returns to IDLE.
- All outputs 0, except ebi_data_out, which is also 0.
- Synchroniser flops reset to 1 (inactive), so releasing reset never creates a strobe edge.
- Counter and read-hold register cleared.

Synchronisation:
- cs_s, oe_s, we_s are the SYNC_STAGES-deep synchronised copies of the three strobes.
- A falling edge is prev = 1 and now = 0 on the synchronised signal.
- ebi_addr and ebi_data_in are sampled raw at the edge cycle. The host must hold them stable for at least SYNC_STAGES+2 clk periods after asserting its strobe.

States: IDLE, RD_WAIT, RD_DRIVE, RELEASE.

IDLE:
- Write: we_s falls while cs_s = 0 and oe_s = 1.
  - Next cycle: cbus_addr = ebi_addr, cbus_wdata = ebi_data_in, cbus_we = 1 for exactly 1 cycle.
  - Go to RELEASE.
- Read: oe_s falls while cs_s = 0 and we_s = 1.
  - Next cycle: cbus_addr = ebi_addr, cbus_oe = 1 for 1 cycle, ebi_wait = 1.
  - Load the down-counter with RD_LATENCY+1.
  - Go to RD_WAIT.
- Both strobes low while cs_s = 0 (simultaneous edges or overlap): no cbus access, proto_err_cnt + 1, go to RELEASE.

RD_WAIT:
- Counter decrements each cycle.
- When the counter reaches 0: capture cbus_rdata into ebi_data_out, ebi_wait = 0.
  - ebi_data_oe = 1 if oe_s = 0 and cs_s = 0; then go to RD_DRIVE.
  - Otherwise (read aborted early): ebi_data_oe stays 0, proto_err_cnt + 1, go to IDLE.
- A we_s falling edge during RD_WAIT is ignored and adds 1 to proto_err_cnt.
- The cbus read always completes. cbus_addr does not change during it.

RD_DRIVE:
- ebi_data_out is held.
- When oe_s = 1 or cs_s = 1: ebi_data_oe = 0 on the next cycle, then go to IDLE.

RELEASE:
- Wait until we_s = 1 and oe_s = 1, or until cs_s = 1, then go to IDLE.
- This guarantees one cbus access per host strobe.

Holding and ordering:
- cbus_addr and cbus_wdata hold their values between transactions. Only a new access updates them.
- cbus_we and cbus_oe are never asserted in the same cycle.

proto_err_cnt:
- 8-bit, saturates at 255, cleared only by reset.

Latency (SYNC_STAGES = 2, RD_LATENCY = 4):
- Read: strobe edge → cbus_oe in about 3 cycles; cbus_oe → data on the pad after 5 cycles.
- Write: strobe edge → cbus_we in about 3 cycles.

Test Plan:
1. Reset release with all strobes high → no cbus_we/cbus_oe pulse for 20 cycles; every output 0; proto_err_cnt = 0.
2. Write addr 0x002, data 0xA5 → exactly one cbus_we pulse carrying cbus_addr = 0x002 and cbus_wdata = 0xA5. Holding we_n low for a further 50 cycles produces no second pulse.
3. Read addr 0x001, with the model register block returning 0x10 four cycles after cbus_oe:
   - ebi_wait = 1 from the cbus_oe cycle, falling 5 cycles later;
   - ebi_data_out = 0x10 and ebi_data_oe = 1 until oe_n rises;
   - cbus_addr = 0x001 throughout.
4. Read aborted (oe_n high 1 cycle after its synchronised fall) → the cbus read still completes; ebi_data_oe never asserts; proto_err_cnt = 1.
5. we_n and oe_n fall together → no cbus strobes; proto_err_cnt increments. Repeating this 300 times → proto_err_cnt = 255.
6. Assert rst_n low during RD_WAIT → ebi_wait, ebi_data_oe and the counter clear immediately. After release, a fresh write to 0x003 with data 0x01 pulses cbus_we once.
